onehot_vector_builder: RTL and testbench
========================================

// Module: onehot_vector_builder
// PURPOSE
//  Inverse of the leading-one index encoder: rebuilds a 9-bit bit-vector from a
//  stream of 5-bit bit-position indices, one index per valid/ready beat.
//  A frame ends on the beat that carries in_last. At frame end the block presents
//  the vector, its population count and an error flag on a valid/ready output.
//  Sits downstream of index producers; 5'b11111 (-1) is the same "no bit" code
//  the encoder emits for an all-zero input.
// PARAMETERS
//  WIDTH  9  number of vector bits; legal indices are 0..WIDTH-1
//  IDX_W  5  index width; the all-ones code means empty/no-op
//  CNT_W  4  population-count width, equal to $clog2(WIDTH+1)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      block can accept a beat (registered)
//  in_index   in   IDX_W  bit position to set
//  in_last    in   1      beat closes the current frame
//  out_valid  out  1      frame result valid
//  out_ready  in   1      consumer accepts the result
//  out_vec    out  WIDTH  rebuilt vector
//  out_count  out  CNT_W  number of distinct bits set in out_vec
//  out_err    out  1      frame contained an index in WIDTH..2^IDX_W-2
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - State goes to ACCUM; in_ready=0; out_valid=0.
//   - out_vec, out_count, out_err, the accumulator, the internal count and the sticky error all clear to 0.
//   - in_ready rises at the first clk edge after rst_n is released.
//  FSM with two states
//   - ACCUM: in_ready=1, out_valid=0.
//   - HOLD:  in_ready=0, out_valid=1.
//  Accepted beat (in_valid & in_ready at a clk edge), by in_index = k:
//   - k < WIDTH: sets acc[k]. The count increments only if acc[k] was 0; a duplicate index changes nothing.
//   - k == all-ones: no-op, with no error.
//   - WIDTH <= k < all-ones: no bit is set and the sticky error is set.
//  Last beat (accepted beat with in_last=1)
//   - The final vector, count and error include that beat's own effect.
//   - They load into out_vec, out_count and out_err on the same edge.
//   - The accumulator, count and error clear; state goes to HOLD.
//   - Latency: out_valid is high in the cycle after the edge that accepted the last beat.
//  HOLD
//   - out_vec, out_count and out_err stay stable until out_valid & out_ready.
//   - At the handshake edge: state goes to ACCUM; out_valid=0 and in_ready=1 from the next cycle.
//   - There is no same-cycle input acceptance during HOLD: in_valid is ignored while in_ready=0.
//  After a handshake, out_* keep the last frame's values until the next load. Consumers sample them only while out_valid=1.
//  in_valid=1 with in_ready=0 is legal and has no effect. The producer holds the beat until it is accepted.
//  An empty frame (a single beat 5'b11111 with last) gives out_vec=0, out_count=0, out_err=0.
//  Reset asserted mid-frame or in HOLD discards all partial and held data immediately.
// TESTING
//  T1 reset: rst_n=0 -> in_ready=0, out_valid=0, out_vec=0; release -> in_ready=1 after 1 edge.
//  T2 frame 8,3,0(last) -> out_vec=9'b100001001, out_count=3, out_err=0, out_valid 1 cycle after last.
//  T3 single beat 5'b11111(last) -> out_vec=0, out_count=0, out_err=0.
//  T4 frame 4,4,12(last) -> out_vec=9'b000010000, out_count=1, out_err=1.
//  T5 out_ready=0 for 5 cycles with in_valid=1 -> out_* stable, in_ready=0, no beat absorbed;
//     out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
//  T6 accept 2,7; pulse rst_n low; release; frame 1(last) -> out_vec=9'b000000010, out_count=1.
//  T7 round trip: for all v=0..511, stream the set-bit indices of v high-to-low (or 5'b11111 if v=0),
//     with random in_valid/out_ready gaps -> out_vec==v and out_count==popcount(v).

Source files
------------

// File: rtl/onehot_vector_builder_if.sv
`default_nettype none
// ============================================================================
// Module      : onehot_vector_builder_if
// Description : Index-stream input and vector-result output handshake bundle
//               for onehot_vector_builder.
// Revision    : 1.0 - initial release
// ============================================================================
interface onehot_vector_builder_if #(
  parameter int WIDTH = 9,
  parameter int IDX_W = 5,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_index;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_vec;
  logic [CNT_W-1:0] out_count;
  logic             out_err;

  // Producer/consumer side (drives beats, accepts results)
  modport master (
    output in_valid, in_index, in_last, out_ready,
    input  in_ready, out_valid, out_vec, out_count, out_err
  );

  // Builder side
  modport slave (
    input  in_valid, in_index, in_last, out_ready,
    output in_ready, out_valid, out_vec, out_count, out_err
  );
endinterface
`default_nettype wire

// File: rtl/onehot_vector_builder.sv
`default_nettype none
// ============================================================================
// Module      : onehot_vector_builder
// Description : Rebuilds a WIDTH-bit vector from a stream of bit-position
//               indices. A frame closes on the beat carrying in_last; the
//               vector, its population count and an out-of-range error flag
//               are then held on a valid/ready output until taken.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_vector_builder #(
  parameter int WIDTH = 9,
  parameter int IDX_W = 5,
  parameter int CNT_W = 4
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  onehot_vector_builder_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_in_ready;
  logic             w_out_valid;
  logic             w_load;

  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic [WIDTH-1:0] r_out_vec;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_err;

  logic             w_accept;
  logic [WIDTH-1:0] w_hit;
  logic             w_in_range;
  logic             w_is_noop;
  logic             w_new_bit;
  logic [WIDTH-1:0] w_acc_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_err_next;

  assign w_accept = bus.in_valid & r_in_ready;

  // Decode the incoming index into a one-hot hit mask; out-of-range codes give an empty mask
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_hit[i] = (bus.in_index == IDX_W'(i));
    end
  end

  assign w_in_range = |w_hit;
  assign w_is_noop  = &bus.in_index;
  // Count only bits not already present so duplicates leave the count alone
  assign w_new_bit  = |(w_hit & ~r_acc);
  assign w_acc_next = r_acc | w_hit;
  assign w_cnt_next = r_cnt + {{(CNT_W-1){1'b0}}, w_new_bit};
  assign w_err_next = r_err | (~w_in_range & ~w_is_noop);

  // State register; in_ready is registered so it stays low for the first edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_ACCUM;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next == ST_ACCUM);
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    w_out_valid  = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        if (w_accept && bus.in_last) begin
          w_load       = 1'b1;
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = ST_ACCUM;
        end
      end
      default: begin
        w_state_next = ST_ACCUM;
      end
    endcase
  end

  // Accumulate accepted beats; the closing beat's own effect goes straight to the result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_out_vec   <= '0;
      r_out_count <= '0;
      r_out_err   <= 1'b0;
    end else if (w_load) begin
      r_out_vec   <= w_acc_next;
      r_out_count <= w_cnt_next;
      r_out_err   <= w_err_next;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_acc_next;
      r_cnt <= w_cnt_next;
      r_err <= w_err_next;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_vec   = r_out_vec;
  assign bus.out_count = r_out_count;
  assign bus.out_err   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_onehot_vector_builder.sv
`default_nettype none
// ============================================================================
// Module      : tb_onehot_vector_builder
// Description : Self-checking bench for onehot_vector_builder with a set-based
//               reference model of each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_vector_builder;

  logic clk = 1'b0;
  logic rst_n;

  onehot_vector_builder_if #(.WIDTH(9), .IDX_W(5), .CNT_W(4)) bus ();

  onehot_vector_builder #(.WIDTH(9), .IDX_W(5), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the set of positions seen in the frame, plus an error flag
  logic [8:0] m_vec;
  bit         m_err;
  int         frame_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_apply(input int k);
    if (k < 9)       m_vec[k] = 1'b1;
    else if (k != 31) m_err   = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send_beat(input logic [4:0] idx, input logic last, input int gap);
    int n;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_index = idx;
    bus.in_last  = last;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("beat_accept", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Streams frame_q, then checks latency, hold stability, result and handshake
  task automatic run_frame(input string tag, input int gap_max, input int hold);
    logic [8:0] held;
    m_vec = '0;
    m_err = 1'b0;
    foreach (frame_q[i]) begin
      model_apply(frame_q[i]);
      send_beat(5'(frame_q[i]), (i == frame_q.size() - 1), $urandom_range(gap_max, 0));
    end
    check({tag, "_valid_latency"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_ready_low"}, {31'd0, bus.in_ready}, 32'd0);
    held = bus.out_vec;
    for (int c = 0; c < hold; c++) begin
      bus.in_valid = 1'b1;
      bus.in_index = 5'($urandom_range(8, 0));
      bus.in_last  = 1'b1;
      @(negedge clk);
      check({tag, "_hold_vec"}, {23'd0, bus.out_vec}, {23'd0, held});
      check({tag, "_hold_ready"}, {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check({tag, "_vec"}, {23'd0, bus.out_vec}, {23'd0, m_vec});
    check({tag, "_count"}, {28'd0, bus.out_count}, $countones(m_vec));
    check({tag, "_err"}, {31'd0, bus.out_err}, {31'd0, m_err});
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_post_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_post_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_index  = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // T1 reset
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_vec", {23'd0, bus.out_vec}, 32'd0);
    check("rst_out_count", {28'd0, bus.out_count}, 32'd0);
    rst_n = 1'b1;
    check("rel_in_ready_0", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    check("rel_in_ready_1", {31'd0, bus.in_ready}, 32'd1);

    // T2 frame 8,3,0
    frame_q = '{8, 3, 0};
    run_frame("t2", 0, 0);
    check("t2_vec_const", {23'd0, bus.out_vec}, 32'h109);

    // T3 empty frame
    frame_q = '{31};
    run_frame("t3", 0, 0);

    // T4 duplicate plus out-of-range
    frame_q = '{4, 4, 12};
    run_frame("t4", 0, 0);
    check("t4_err_const", {31'd0, bus.out_err}, 32'd1);

    // T5 long hold with in_valid asserted; the next frame shows nothing leaked in
    frame_q = '{6};
    run_frame("t5", 0, 5);
    frame_q = '{1};
    run_frame("t5b", 0, 0);

    // T6 reset mid-frame
    send_beat(5'd2, 1'b0, 0);
    send_beat(5'd7, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("t6_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t6_rst_out_vec", {23'd0, bus.out_vec}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
    frame_q = '{1};
    run_frame("t6", 0, 0);
    check("t6_vec_const", {23'd0, bus.out_vec}, 32'h002);

    // Random frames of arbitrary 5-bit indices
    for (int f = 0; f < 30; f++) begin
      frame_q = {};
      for (int b = 0; b < int'($urandom_range(6, 1)); b++) begin
        frame_q.push_back(int'($urandom_range(31, 0)));
      end
      run_frame("rnd", 2, $urandom_range(2, 0));
    end

    // T7 round trip over every 9-bit value
    for (int v = 0; v < 512; v++) begin
      frame_q = {};
      for (int b = 8; b >= 0; b--) begin
        if ((v >> b) & 1) frame_q.push_back(b);
      end
      if (frame_q.size() == 0) frame_q.push_back(31);
      run_frame("t7", 2, $urandom_range(3, 0));
      check("t7_vec_v", {23'd0, bus.out_vec}, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
